// File: rtl/clk_div_prog.sv
// Programmable clock divider and tick generator.
// Divisor is double-buffered: writes land in a shadow register and are moved
// to the active divisor only at a terminal count or a synchronous restart,
// so a period in progress is never cut short or stretched.
//
// Output modes:
//   MODE_in = 0 : CLK_out toggles at every terminal count (period 2*D)
//   MODE_in = 1 : CLK_out mirrors TICK_out (one-cycle pulse every D cycles)
module clk_div_prog #(
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 99999
) (
    input  logic             CLK_in,
    input  logic             RST_in,
    input  logic             EN_in,
    input  logic             MODE_in,
    input  logic [WIDTH-1:0] DIV_in,
    input  logic             DIV_we_in,
    input  logic             SYNC_in,
    output logic             CLK_out,
    output logic             TICK_out,
    output logic             PEND_out,
    output logic [WIDTH-1:0] CNT_out
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_shd;
    logic [WIDTH-1:0] div_eff;
    logic             clk_q;
    logic             tick_q;
    logic             pend;
    logic             term;

    // Effective divisor clamps 0 to 1; terminal uses >= as a guard against
    // a counter that somehow sits beyond the last state.
    always_comb begin
        div_eff = (div_act == '0) ? ONE : div_act;
        term    = EN_in && (cnt >= (div_eff - ONE));
    end

    // Counter, output and divisor-buffer update; SYNC_in outranks counting.
    always_ff @(posedge CLK_in or posedge RST_in) begin
        if (RST_in) begin
            cnt     <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            pend    <= 1'b0;
            div_act <= DIV_RST;
            div_shd <= DIV_RST;
        end else if (SYNC_in) begin
            cnt    <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            // A write in the same cycle is the newest value and wins.
            if (DIV_we_in) begin
                div_act <= DIV_in;
                div_shd <= DIV_in;
                pend    <= 1'b0;
            end else if (pend) begin
                div_act <= div_shd;
                pend    <= 1'b0;
            end
        end else begin
            if (EN_in && term) begin
                cnt    <= '0;
                tick_q <= 1'b1;
                clk_q  <= MODE_in ? 1'b1 : ~clk_q;
                // The terminal consumes the shadow as it was before this edge;
                // a coincident write remains pending for the next terminal.
                if (pend) begin
                    div_act <= div_shd;
                end
            end else if (EN_in) begin
                cnt    <= cnt + ONE;
                tick_q <= 1'b0;
                clk_q  <= MODE_in ? 1'b0 : clk_q;
            end else begin
                tick_q <= 1'b0;
                clk_q  <= MODE_in ? 1'b0 : clk_q;
            end

            if (DIV_we_in) begin
                div_shd <= DIV_in;
                pend    <= 1'b1;
            end else if (EN_in && term) begin
                pend    <= 1'b0;
            end
        end
    end

    assign CLK_out  = clk_q;
    assign TICK_out = tick_q;
    assign PEND_out = pend;
    assign CNT_out  = cnt;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog with WIDTH=8, DEFAULT_DIV=4.
// Vector table expectations are hand-derived from the divider behaviour;
// multi-cycle corner cases (async reset, SYNC restart) are hand sequences.
module tb_clk_div_prog;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       en_in;
    logic       mode_in;
    logic [7:0] div_in;
    logic       div_we_in;
    logic       sync_in;
    logic       clk_out;
    logic       tick_out;
    logic       pend_out;
    logic [7:0] cnt_out;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       en;
        logic       mode;
        logic       we;
        logic [7:0] div;
        logic [7:0] cnt;
        logic       tick;
        logic       clk;
        logic       pend;
    } vec_t;

    typedef struct {
        logic [7:0] cnt;
        logic       tick;
        logic       clk;
        logic       pend;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
        .CLK_in    (clk_in),
        .RST_in    (rst_in),
        .EN_in     (en_in),
        .MODE_in   (mode_in),
        .DIV_in    (div_in),
        .DIV_we_in (div_we_in),
        .SYNC_in   (sync_in),
        .CLK_out   (clk_out),
        .TICK_out  (tick_out),
        .PEND_out  (pend_out),
        .CNT_out   (cnt_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic vec_t mk(input logic en, input logic mode, input logic we,
                                input logic [7:0] div, input logic [7:0] cnt,
                                input logic tick, input logic clk, input logic pend);
        vec_t v;
        v.en = en; v.mode = mode; v.we = we; v.div = div;
        v.cnt = cnt; v.tick = tick; v.clk = clk; v.pend = pend;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Counts rising edges until TICK_out is seen; 0 means the budget expired.
    task automatic edges_to_tick(input int budget, output int n);
        n = 0;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk_in);
            #1;
            if (tick_out) begin
                n = k;
                return;
            end
        end
    endtask

    initial begin
        int n;
        exp_t e;

        // Test 1: toggle mode, D=4
        vecs.push_back(mk(1,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,0,0,0, 2,0,0,0));
        vecs.push_back(mk(1,0,0,0, 3,0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,1,1,0));
        vecs.push_back(mk(1,0,0,0, 1,0,1,0));
        vecs.push_back(mk(1,0,0,0, 2,0,1,0));
        vecs.push_back(mk(1,0,0,0, 3,0,1,0));
        vecs.push_back(mk(1,0,0,0, 0,1,0,0));
        // Test 2: pulse mode, write 3 at counter=1
        vecs.push_back(mk(1,1,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,1,3, 2,0,0,1));
        vecs.push_back(mk(1,1,0,0, 3,0,0,1));
        vecs.push_back(mk(1,1,0,0, 0,1,1,0));
        vecs.push_back(mk(1,1,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,0,0, 2,0,0,0));
        vecs.push_back(mk(1,1,0,0, 0,1,1,0));
        vecs.push_back(mk(1,1,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,0,0, 2,0,0,0));
        vecs.push_back(mk(1,1,0,0, 0,1,1,0));
        // Test 5: back to toggle from a high pulse, then hold with EN=0
        vecs.push_back(mk(1,0,0,0, 1,0,1,0));
        for (int k = 0; k < 5; k++) vecs.push_back(mk(0,0,0,0, 1,0,1,0));
        vecs.push_back(mk(1,0,0,0, 2,0,1,0));
        vecs.push_back(mk(1,0,0,0, 0,1,0,0));
        // Test 4: write 5 coincident with terminal (D=3)
        vecs.push_back(mk(1,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,0,0,0, 2,0,0,0));
        vecs.push_back(mk(1,0,1,5, 0,1,1,1));
        vecs.push_back(mk(1,0,0,0, 1,0,1,1));
        vecs.push_back(mk(1,0,0,0, 2,0,1,1));
        vecs.push_back(mk(1,0,0,0, 0,1,0,0));
        vecs.push_back(mk(1,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,0,0,0, 2,0,0,0));
        vecs.push_back(mk(1,0,0,0, 3,0,0,0));
        vecs.push_back(mk(1,0,0,0, 4,0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,1,1,0));
        // Test 3: write 0 then 2, last write wins
        vecs.push_back(mk(1,0,1,0, 1,0,1,1));
        vecs.push_back(mk(1,0,1,2, 2,0,1,1));
        vecs.push_back(mk(1,0,0,0, 3,0,1,1));
        vecs.push_back(mk(1,0,0,0, 4,0,1,1));
        vecs.push_back(mk(1,0,0,0, 0,1,0,0));
        vecs.push_back(mk(1,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,1,1,0));
        // Divisor 0 behaves as 1
        vecs.push_back(mk(1,0,1,0, 1,0,1,1));
        vecs.push_back(mk(1,0,0,0, 0,1,0,0));
        vecs.push_back(mk(1,0,0,0, 0,1,1,0));
        vecs.push_back(mk(1,0,0,0, 0,1,0,0));
        vecs.push_back(mk(1,1,0,0, 0,1,1,0));
        vecs.push_back(mk(1,1,0,0, 0,1,1,0));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0));

        rst_in = 1'b1; en_in = 1'b0; mode_in = 1'b0;
        div_in = '0; div_we_in = 1'b0; sync_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_cnt",  32'(cnt_out),  0);
        check("rst_clk",  32'(clk_out),  0);
        check("rst_tick", 32'(tick_out), 0);
        check("rst_pend", 32'(pend_out), 0);
        @(negedge clk_in);
        rst_in = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk_in);
            en_in = vecs[i].en; mode_in = vecs[i].mode;
            div_we_in = vecs[i].we; div_in = vecs[i].div;
            e.cnt = vecs[i].cnt; e.tick = vecs[i].tick;
            e.clk = vecs[i].clk; e.pend = vecs[i].pend;
            sb.push_back(e);
            @(posedge clk_in);
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d_cnt", i),  32'(cnt_out),  32'(e.cnt));
            check($sformatf("v%0d_tick", i), 32'(tick_out), 32'(e.tick));
            check($sformatf("v%0d_clk", i),  32'(clk_out),  32'(e.clk));
            check($sformatf("v%0d_pend", i), 32'(pend_out), 32'(e.pend));
        end

        // Test 6a: async reset with a divisor pending
        @(negedge clk_in);
        en_in = 1'b0; mode_in = 1'b0; div_we_in = 1'b1; div_in = 8'd7;
        @(negedge clk_in);
        div_we_in = 1'b0;
        check("pend_before_rst", 32'(pend_out), 1);
        #2;
        rst_in = 1'b1;
        #1;
        check("async_cnt",  32'(cnt_out),  0);
        check("async_clk",  32'(clk_out),  0);
        check("async_tick", 32'(tick_out), 0);
        check("async_pend", 32'(pend_out), 0);
        @(negedge clk_in);
        en_in = 1'b1;
        rst_in = 1'b0;
        edges_to_tick(20, n);
        check("latency_after_rst", 32'(n), 4);
        check("clk_first_tick", 32'(clk_out), 1);

        // Test 6b: SYNC applies pending divisor 6
        @(negedge clk_in);
        div_we_in = 1'b1; div_in = 8'd6;
        @(negedge clk_in);
        div_we_in = 1'b0;
        check("pend_6", 32'(pend_out), 1);
        @(negedge clk_in);
        sync_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("sync_cnt",  32'(cnt_out),  0);
        check("sync_clk",  32'(clk_out),  0);
        check("sync_pend", 32'(pend_out), 0);
        @(negedge clk_in);
        sync_in = 1'b0;
        edges_to_tick(30, n);
        check("tick_after_sync", 32'(n), 6);
        edges_to_tick(30, n);
        check("period_6", 32'(n), 6);

        // SYNC with a same-cycle write uses the new value immediately
        @(negedge clk_in);
        sync_in = 1'b1; div_we_in = 1'b1; div_in = 8'd3;
        @(posedge clk_in);
        #1;
        check("sync_we_pend", 32'(pend_out), 0);
        @(negedge clk_in);
        sync_in = 1'b0; div_we_in = 1'b0;
        edges_to_tick(30, n);
        check("tick_after_sync_we", 32'(n), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
